// File: rtl/fetch_stage.sv
// fetch_stage: PC, synchronous ROM fetch, one-entry skid buffer, redirects.
// Optional FETCH_MISALIGN_CHECK_EN: sticky fault on misaligned redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_dout,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fetch_fault
);

  logic [31:0] pc_q, pc_d;
  logic        resp_pending_q, resp_pending_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        fault_q;
  logic [31:0] tgt;
  logic        redir_ok;
  logic        redir_bad;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_d;

  assign tgt       = redirect_target;
  assign redir_ok  = redirect_valid && !fault_q
                     && (tgt[1:0] == 2'b00);
  assign redir_bad = redirect_valid && !fault_q
                     && (tgt[1:0] != 2'b00);
  assign fault_d   = fault_q | redir_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`else
  assign tgt       = redirect_target & ~32'h3;
  assign redir_ok  = redirect_valid;
  assign redir_bad = 1'b0;
  assign fault_q   = 1'b0;
`endif

  assign fetch_fault = fault_q;

  always_comb begin
    pc_d           = pc_q;
    resp_pending_d = 1'b0;
    resp_pc_d      = resp_pc_q;
    skid_valid_d   = skid_valid_q;
    skid_instr_d   = skid_instr_q;
    skid_pc_d      = skid_pc_q;
    imem_addr      = pc_q;
    imem_en        = 1'b0;
    if (rst) begin
      imem_addr = RESET_PC;
    end else if (redir_ok) begin
      imem_addr      = tgt;
      imem_en        = 1'b1;
      resp_pc_d      = tgt;
      pc_d           = tgt + 32'd4;
      resp_pending_d = 1'b1;
      skid_valid_d   = 1'b0;
    end else if (redir_bad || fault_q) begin
      skid_valid_d = 1'b0;
    end else if (!stall) begin
      imem_en        = 1'b1;
      resp_pc_d      = pc_q;
      pc_d           = pc_q + 32'd4;
      resp_pending_d = 1'b1;
      skid_valid_d   = 1'b0;
    end else if (resp_pending_q && !skid_valid_q) begin
      // stalled ROM word would be lost next edge; park it
      skid_valid_d = 1'b1;
      skid_instr_d = imem_dout;
      skid_pc_d    = resp_pc_q;
    end
  end

  assign if_valid = (skid_valid_q || resp_pending_q)
                    && !rst && !fault_q
                    && !redir_ok && !redir_bad;

  assign if_instr = !if_valid    ? 32'h0 :
                    skid_valid_q ? skid_instr_q : imem_dout;
  assign if_pc    = !if_valid    ? 32'h0 :
                    skid_valid_q ? skid_pc_q : resp_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      resp_pending_q <= 1'b0;
      resp_pc_q      <= RESET_PC;
      skid_valid_q   <= 1'b0;
      skid_instr_q   <= 32'h0;
      skid_pc_q      <= 32'h0;
    end else begin
      pc_q           <= pc_d;
      resp_pending_q <= resp_pending_d;
      resp_pc_q      <= resp_pc_d;
      skid_valid_q   <= skid_valid_d;
      skid_instr_q   <= skid_instr_d;
      skid_pc_q      <= skid_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against a small ROM model.
// ROM word at byte address a is {16'hC0DE, a[15:0]}.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_dout = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_en         (imem_en),
    .imem_dout       (imem_dout),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_dout <= rom(imem_addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [97:0] exp;
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp = {1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
      checks++;
      if ({imem_en, if_valid, imem_addr, if_pc, if_instr} !== exp) begin
        errors++;
        $display("FAIL reset_hold%0d got %h exp %h", i,
                 {imem_en, if_valid, imem_addr, if_pc, if_instr}, exp);
      end
      checks++;
      if (fetch_fault !== 1'b0) begin
        errors++;
        $display("FAIL reset_fault got %b exp 0", fetch_fault);
      end
      step();
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_en, if_valid, imem_addr} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_first_issue got %h exp %h",
               {imem_en, if_valid, imem_addr}, {1'b1, 1'b0, 32'h0});
    end
    step();
    @(negedge clk);
    checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, rom(32'h0)}) begin
      errors++;
      $display("FAIL reset_first_word got %h exp %h",
               {if_valid, if_pc, if_instr}, {1'b1, 32'h0, rom(32'h0)});
    end
    step();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({imem_en, if_valid, imem_addr} !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_midstream got %h exp %h",
               {imem_en, if_valid, imem_addr}, {1'b0, 1'b0, 32'h0});
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_en, if_valid, imem_addr} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_after_mid got %h exp %h",
               {imem_en, if_valid, imem_addr}, {1'b1, 1'b0, 32'h0});
    end
  endtask

  task automatic test_streaming();
    logic [64:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = {1'b1, 32'(4 * i), rom(32'(4 * i))};
      checks++;
      if ({if_valid, if_pc, if_instr} !== exp) begin
        errors++;
        $display("FAIL stream%0d got %h exp %h", i,
                 {if_valid, if_pc, if_instr}, exp);
      end
      step();
    end
  endtask

  task automatic test_back_pressure();
    logic [64:0] exp;
    do_reset();
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp = {1'b1, 32'h8, rom(32'h8)};
      checks++;
      if ({if_valid, if_pc, if_instr} !== exp || imem_en !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got %h en %b exp %h en 0", i,
                 {if_valid, if_pc, if_instr}, imem_en, exp);
      end
      step();
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_valid, if_pc, imem_en, imem_addr} !== {1'b1, 32'h8, 1'b1, 32'hC}) begin
      errors++;
      $display("FAIL bp_release got %h exp %h",
               {if_valid, if_pc, imem_en, imem_addr},
               {1'b1, 32'h8, 1'b1, 32'hC});
    end
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp = {1'b1, 32'(12 + 4 * i), rom(32'(12 + 4 * i))};
      checks++;
      if ({if_valid, if_pc, if_instr} !== exp) begin
        errors++;
        $display("FAIL bp_after%0d got %h exp %h", i,
                 {if_valid, if_pc, if_instr}, exp);
      end
      step();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    step();
    redirect_valid = 1'b1;
    redirect_target = 32'hC;
    @(negedge clk);
    checks++;
    if ({imem_en, imem_addr, if_valid, if_pc} !== {1'b1, 32'hC, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL redir_cycle got %h exp %h",
               {imem_en, imem_addr, if_valid, if_pc},
               {1'b1, 32'hC, 1'b0, 32'h0});
    end
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'hC, rom(32'hC)}) begin
      errors++;
      $display("FAIL redir_target got %h exp %h",
               {if_valid, if_pc, if_instr}, {1'b1, 32'hC, rom(32'hC)});
    end
    step();
    @(negedge clk);
    checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h10, rom(32'h10)}) begin
      errors++;
      $display("FAIL redir_next got %h exp %h",
               {if_valid, if_pc, if_instr}, {1'b1, 32'h10, rom(32'h10)});
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    step();
    step();
    stall = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if ({if_valid, if_pc} !== {1'b1, 32'h8}) begin
      errors++;
      $display("FAIL rs_skid got %h exp %h", {if_valid, if_pc}, {1'b1, 32'h8});
    end
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    #1;
    checks++;
    if ({if_valid, imem_en, imem_addr} !== {1'b0, 1'b1, 32'h40}) begin
      errors++;
      $display("FAIL rs_cycle got %h exp %h",
               {if_valid, imem_en, imem_addr}, {1'b0, 1'b1, 32'h40});
    end
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h40, rom(32'h40)}) begin
        errors++;
        $display("FAIL rs_target%0d got %h exp %h", i,
                 {if_valid, if_pc, if_instr}, {1'b1, 32'h40, rom(32'h40)});
      end
      step();
    end
    stall = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_valid, if_pc, imem_en} !== {1'b1, 32'h40, 1'b1}) begin
      errors++;
      $display("FAIL rs_release got %h exp %h",
               {if_valid, if_pc, imem_en}, {1'b1, 32'h40, 1'b1});
    end
    step();
    @(negedge clk);
    checks++;
    if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h44, rom(32'h44)}) begin
      errors++;
      $display("FAIL rs_next got %h exp %h",
               {if_valid, if_pc, if_instr}, {1'b1, 32'h44, rom(32'h44)});
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    step();
    redirect_valid = 1'b1;
    redirect_target = 32'h42;
    @(negedge clk);
`ifdef FETCH_MISALIGN_CHECK_EN
    checks++;
    if ({imem_en, if_valid, fetch_fault} !== 3'b000) begin
      errors++;
      $display("FAIL mis_cycle got %b exp 000", {imem_en, if_valid, fetch_fault});
    end
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        redirect_valid = 1'b1;
        redirect_target = 32'h80;
      end else begin
        redirect_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if ({fetch_fault, if_valid, imem_en} !== 3'b100) begin
        errors++;
        $display("FAIL mis_fault%0d got %b exp 100", i,
                 {fetch_fault, if_valid, imem_en});
      end
      step();
    end
`else
    checks++;
    if ({imem_en, imem_addr, if_valid, fetch_fault} !== {1'b1, 32'h40, 2'b00}) begin
      errors++;
      $display("FAIL mis_cycle got %h exp %h",
               {imem_en, imem_addr, if_valid, fetch_fault},
               {1'b1, 32'h40, 2'b00});
    end
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_valid, if_pc, if_instr, fetch_fault} !== {1'b1, 32'h40, rom(32'h40), 1'b0}) begin
      errors++;
      $display("FAIL mis_target got %h exp %h",
               {if_valid, if_pc, if_instr, fetch_fault},
               {1'b1, 32'h40, rom(32'h40), 1'b0});
    end
`endif
    do_reset();
    @(negedge clk);
    checks++;
    if ({fetch_fault, if_valid, if_pc} !== {1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL mis_reset got %h exp %h",
               {fetch_fault, if_valid, if_pc}, {1'b0, 1'b1, 32'h0});
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_redirect();
    test_redirect_stall();
    test_misaligned();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
